// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// Optional input digit check: define BCD_DIGIT_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [BW-1:0]    bcd_reg;
  logic [BW-1:0]    bcd_d;
  logic [BW-1:0]    bcd_step;
  logic [BIN_W-1:0] res_reg;
  logic [BIN_W-1:0] res_d;
  logic [BIN_W-1:0] res_step;
  logic [BIN_W-1:0] bin_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             busy_d;
  logic             done_d;
  logic             last;
  logic             reject;

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q;
  logic err_d;

  // Flag any input digit above 9 so the job is rejected up front
  always_comb begin
    reject = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        reject = 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  // One iteration: shift the pair right, then correct digits >= 8 by -3
  always_comb begin
    bcd_step = bcd_reg >> 1;
    res_step = {bcd_reg[0], res_reg[BIN_W-1:1]};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_step[4*i+3]) begin
        bcd_step[4*i +: 4] = bcd_step[4*i +: 4] - 4'd3;
      end
    end
  end

  assign last = (cnt == CW'(BIN_W - 1));

  // Next-state and next-register values for the controller and datapath
  always_comb begin
    state_d = state;
    bcd_d   = bcd_reg;
    res_d   = res_reg;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    bin_d   = bin_out;
`ifdef BCD_DIGIT_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (reject) begin
            done_d = 1'b1;
            bin_d  = '0;
            busy_d = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_d  = 1'b1;
`endif
          end else begin
            bcd_d   = bcd_in;
            res_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_step;
        res_d = res_step;
        cnt_d = cnt + CW'(1);
        if (last) begin
          bin_d   = res_step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      res_reg <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      bcd_reg <= bcd_d;
      res_reg <= res_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      bin_out <= bin_d;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq.
// Expected values come from decimal digit arithmetic.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
  localparam int BW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [BW-1:0]    bcd_in = '0;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    logic             dc;
    int               due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int dec_val(input logic [BW-1:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [BW-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int n);
    logic [BW-1:0] r = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m /= 10;
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present start for one edge; when acc is set, record the expected result
  task automatic do_start(input logic [BW-1:0] v, input bit acc);
    exp_t e;
    start  = 1'b1;
    bcd_in = v;
    tick(1);
    start  = 1'b0;
    bcd_in = BW'($urandom);
    if (acc) begin
      e.dc = 1'b0;
      e.bin = BIN_W'(dec_val(v));
      e.err = 1'b0;
      e.due = cyc + BIN_W;
      if (has_bad_digit(v)) begin
`ifdef BCD_DIGIT_CHECK_EN
        e.bin = '0;
        e.err = 1'b1;
        e.due = cyc;
`else
        e.dc = 1'b1;
`endif
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      tick(1);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d results pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compare handshake and results against the scoreboard
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_done: none at cycle %0d, required one", q[0].due);
        void'(q.pop_front());
      end
      check("done", int'(done), int'(q.size() > 0 && q[0].due == cyc));
      check("busy", int'(busy), int'(q.size() > 0 && q[0].due > cyc));
      if (done && q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        if (!e.dc) check("bin_out", int'(bin_out), int'(e.bin));
        check("err", int'(err), int'(e.err));
      end
    end
  end

  initial begin
    tick(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bin", int'(bin_out), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    tick(1);
    mon_on = 1'b1;

    do_start(12'h010, 1'b1);
    wait_done();
    do_start(12'h999, 1'b1);
    wait_done();
    do_start(12'h000, 1'b1);
    wait_done();

    do_start(12'h255, 1'b1);
    tick(2);
    do_start(12'h777, 1'b0);
    wait_done();

    do_start(12'h123, 1'b1);
    tick(3);
    rst = 1'b1;
    q.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bin", int'(bin_out), 0);
    check("abort_err", int'(err), 0);
    tick(1);
    rst = 1'b0;
    tick(12);
    do_start(12'h042, 1'b1);
    wait_done();

    do_start(12'h314, 1'b1);
    tick(BIN_W);
    do_start(12'h628, 1'b1);
    wait_done();

    do_start(12'h1A3, 1'b1);
    wait_done();

    for (int i = 0; i < 40; i++) begin
      do_start(to_bcd(int'($urandom_range(0, 999))), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        tick(int'($urandom_range(0, 7)));
        do_start(BW'($urandom), 1'b0);
      end
      wait_done();
      tick(int'($urandom_range(0, 3)));
    end

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter using reverse double dabble.
- Each cycle: shift right by one, then subtract 3 from any BCD digit that is ≥ 8.
- Inverse of the binary-to-BCD path built from add3 cells.
- Sits between decimal entry logic (keypad/switch digits) and binary arithmetic; start/busy/done handshake.

Parameters:
- DIGITS, 3, number of packed BCD digits at the input.
- BIN_W, 10, binary result width and number of shift cycles. Must satisfy 2^BIN_W ≥ 10^DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0]; sampled on accepted start.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when bin_out/err are valid.
- bin_out  output  BIN_W  converted value; held until the next accepted start.
- err  output  1  invalid-digit flag (see Optional Feature); held with bin_out.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy = 0, done = 0, bin_out = 0, err = 0.
  - Internal BCD shift register, result register and counter all cleared.
- States: IDLE, SHIFT.
- IDLE:
  - done is low except during the single pulse cycle.
  - start = 1 at a clock edge:
    - load bcd_in into the BCD register (4*DIGITS bits);
    - clear the result register (BIN_W bits) and counter;
    - busy = 1 from this edge; go to SHIFT.
- SHIFT, one iteration per clock:
  - {bcd_reg, res_reg} shifts right by one; LSB of bcd_reg enters MSB of res_reg.
  - Then every 4-bit digit of the shifted bcd_reg that is ≥ 8 has 3 subtracted, all digits in parallel in the same cycle.
  - Counter increments.
  - On the edge completing iteration BIN_W:
    - bin_out = final res_reg;
    - err = 0;
    - done = 1 for exactly one cycle;
    - busy = 0; return to IDLE.
- Latency: done is high in the cycle after edge k+BIN_W, where k is the accepting edge (10 cycles at default). Throughput is one conversion per BIN_W+1 cycles minimum.
- start while busy: ignored; the current conversion is unaffected.
- start in the done cycle: state is IDLE, so it is accepted; done still pulses only once.
- bcd_in changes after the accepting edge: no effect.
- Width rule: with 2^BIN_W ≥ 10^DIGITS, bcd_reg is zero after BIN_W iterations and the result is exact.
- Reset mid-conversion: immediate return to IDLE with all outputs zero. No done is issued for the aborted job.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - On an accepted start, if any input digit is > 9: no shifting occurs.
  - Next edge: done = 1, err = 1, bin_out = 0, busy = 0; state stays IDLE.
  - Valid input converts normally with err = 0.
- Undefined:
  - No check is performed; err is tied to 0.
  - Invalid digits convert through the algorithm unchanged; the result is deterministic but meaningless.

Test Plan:
- Reset, then start with bcd_in=12'h010 → busy high for 10 cycles; done pulses once; bin_out=10'd10, err=0.
- bcd_in=12'h999 → bin_out=10'd999 (0x3E7); bcd_in=12'h000 → bin_out=0; both after exactly 10 cycles.
- Start with 12'h255, pulse start again 3 cycles later with 12'h777 → second start ignored; bin_out=255; a single done pulse.
- Start with 12'h123; assert rst at cycle 4 → outputs 0 immediately, no done. After release, start with 12'h042 → bin_out=42.
- Start with 12'h314, assert start with 12'h628 during the done cycle → done for 314, then 10 cycles later done for 628. Back-to-back acceptance confirmed.
- With BCD_DIGIT_CHECK_EN: bcd_in=12'h1A3 → done one cycle after start, err=1, bin_out=0. Without the macro: err stays 0 and done arrives after 10 cycles.
